// File: rtl/sens_ascii_parser.sv
// Decodes ASCII frames "SENS: <1-3 digits><sp|CR|LF>" into an 8-bit value with a valid/ready output.
// Define SENS_PARSER_TIMEOUT_EN to abandon partial frames after TIMEOUT_CYCLES idle cycles.
module sens_ascii_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_char,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       err,
  output logic [1:0] err_code
);

  typedef enum logic [2:0] {
    StIdle, StS1, StE, StN, StS2, StColon, StSpace, StDig
  } state_e;

  localparam logic [1:0] ErrSyntax   = 2'd1;
  localparam logic [1:0] ErrOverflow = 2'd2;

  state_e     state_q, state_d;
  logic [9:0] acc_q, acc_d;
  logic [1:0] cnt_q, cnt_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] out_data_q, out_data_d;
  logic       err_q, err_d;
  logic [1:0] err_code_q, err_code_d;

  logic       xfer;
  logic       is_digit;
  logic       is_term;
  logic       is_s;
  logic [3:0] digit_val;
  logic       syntax_err;

  assign in_ready  = ~out_valid_q;
  assign xfer      = in_valid & in_ready;
  assign is_digit  = (in_char[7:4] == 4'h3) && (in_char[3:0] <= 4'd9);
  assign is_term   = (in_char == 8'h20) || (in_char == 8'h0d) || (in_char == 8'h0a);
  assign is_s      = (in_char == 8'h53);
  // ASCII '0'..'9' carry their value in the low nibble.
  assign digit_val = in_char[3:0];

`ifdef SENS_PARSER_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
  logic [ToW-1:0] to_q, to_d;
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q & ~out_ready;
    out_data_d  = out_data_q;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    syntax_err  = 1'b0;
`ifdef SENS_PARSER_TIMEOUT_EN
    to_d        = '0;
`endif

    if (xfer) begin
      case (state_q)
        StIdle: begin
          if (is_s) begin
            state_d = StS1;
            acc_d   = '0;
            cnt_d   = '0;
          end
        end
        StS1:    if (in_char == 8'h45) state_d = StE;     else syntax_err = 1'b1;
        StE:     if (in_char == 8'h4e) state_d = StN;     else syntax_err = 1'b1;
        StN:     if (is_s)             state_d = StS2;    else syntax_err = 1'b1;
        StS2:    if (in_char == 8'h3a) state_d = StColon; else syntax_err = 1'b1;
        StColon: if (in_char == 8'h20) state_d = StSpace; else syntax_err = 1'b1;
        StSpace: begin
          if (is_digit) begin
            state_d = StDig;
            acc_d   = {6'd0, digit_val};
            cnt_d   = 2'd1;
          end else begin
            syntax_err = 1'b1;
          end
        end
        StDig: begin
          if (is_digit) begin
            if (cnt_q == 2'd3) begin
              syntax_err = 1'b1;
            end else begin
              acc_d = acc_q * 10'd10 + {6'd0, digit_val};
              cnt_d = cnt_q + 2'd1;
            end
          end else if (is_term) begin
            state_d = StIdle;
            if (acc_q <= 10'd255) begin
              out_valid_d = 1'b1;
              out_data_d  = acc_q[7:0];
            end else begin
              err_d      = 1'b1;
              err_code_d = ErrOverflow;
            end
          end else begin
            syntax_err = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // An offending 'S' is taken as the start of a fresh frame.
    if (syntax_err) begin
      err_d      = 1'b1;
      err_code_d = ErrSyntax;
      if (is_s) begin
        state_d = StS1;
        acc_d   = '0;
        cnt_d   = '0;
      end else begin
        state_d = StIdle;
      end
    end

`ifdef SENS_PARSER_TIMEOUT_EN
    if ((state_q != StIdle) && !xfer) begin
      to_d = to_q + ToW'(1);
      if (to_d == ToW'(TIMEOUT_CYCLES)) begin
        state_d    = StIdle;
        err_d      = 1'b1;
        err_code_d = 2'd3;
        to_d       = '0;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

`ifdef SENS_PARSER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      to_q <= '0;
    end else begin
      to_q <= to_d;
    end
  end
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_sens_ascii_parser.sv
// Bench for sens_ascii_parser: frame-level string model, vector table, corner sequences, random frames.
module tb_sens_ascii_parser;

`ifdef SENS_PARSER_TIMEOUT_EN
  localparam int unsigned TO = 16;
`else
  localparam int unsigned TO = 1000;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_char;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       err;
  logic [1:0] err_code;

  sens_ascii_parser #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_char   (in_char),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .err       (err),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: bytes of the frame matched so far (empty = not in a frame).
  logic [7:0] fq[$];
  string      hdr;
  bit         m_ov;
  int         m_data;
  bit         m_err;
  int         m_code;
  int         m_to;

  // Observation stats for the vector table.
  int  obs_outs, obs_data, obs_errs;
  bit  prev_ov;

  function automatic void chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void m_reset();
    fq.delete();
    m_ov = 0; m_data = 0; m_err = 0; m_code = 0; m_to = 0;
  endfunction

  function automatic void m_syntax(logic [7:0] c);
    m_err  = 1;
    m_code = 1;
    fq.delete();
    if (c == "S") fq.push_back(c);
  endfunction

  function automatic void m_char(logic [7:0] c);
    int n     = fq.size();
    bit dig   = (c >= 8'h30) && (c <= 8'h39);
    bit term  = (c == 8'h20) || (c == 8'h0d) || (c == 8'h0a);
    int val;
    if (n == 0) begin
      if (c == "S") fq.push_back(c);
    end else if (n < 6) begin
      if (c == hdr[n]) fq.push_back(c);
      else m_syntax(c);
    end else if (dig && n < 9) begin
      fq.push_back(c);
    end else if (term && n > 6) begin
      val = 0;
      for (int i = 6; i < n; i++) val = val * 10 + int'(fq[i]) - 48;
      if (val <= 255) begin
        m_ov   = 1;
        m_data = val;
      end else begin
        m_err  = 1;
        m_code = 2;
      end
      fq.delete();
    end else begin
      m_syntax(c);
    end
  endfunction

  function automatic void m_step(bit v, logic [7:0] c, bit ordy);
    bit xfer = v && !m_ov;
    m_err = 0;
    if (m_ov && ordy) m_ov = 0;
`ifdef SENS_PARSER_TIMEOUT_EN
    if (fq.size() != 0 && !xfer) begin
      m_to++;
      if (m_to == TO) begin
        m_err  = 1;
        m_code = 3;
        fq.delete();
        m_to   = 0;
      end
    end else begin
      m_to = 0;
    end
`endif
    if (xfer) m_char(c);
  endfunction

  // One clock: drive, check in_ready, advance model, step clock, check registered outputs.
  task automatic tick(input bit v, input logic [7:0] c, input bit ordy, output bit xfer);
    in_valid  = v;
    in_char   = c;
    out_ready = ordy;
    #1;
    chk("in_ready", int'(in_ready), int'(!m_ov));
    xfer = v && in_ready;
    m_step(v, c, ordy);
    @(posedge clk);
    #1;
    chk("out_valid", int'(out_valid), int'(m_ov));
    chk("out_data", int'(out_data), m_data);
    chk("err", int'(err), int'(m_err));
    chk("err_code", int'(err_code), m_code);
    if (out_valid && !prev_ov) begin
      obs_outs++;
      obs_data = int'(out_data);
    end
    if (err) obs_errs++;
    prev_ov = out_valid;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_char   = "S";
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    m_reset();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_err_code", int'(err_code), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    obs_outs = 0; obs_data = -1; obs_errs = 0; prev_ov = 0;
  endtask

  task automatic send_char(input logic [7:0] c, input bit ordy);
    bit x;
    for (int g = 0; g < 50; g++) begin
      tick(1'b1, c, ordy, x);
      if (x) return;
    end
    chk("send_timeout", 0, 1);
  endtask

  task automatic send_str(input string s, input bit ordy);
    for (int i = 0; i < s.len(); i++) send_char(s[i], ordy);
  endtask

  task automatic idle(input int n, input bit ordy);
    bit x;
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, ordy, x);
  endtask

  typedef struct {
    string txt;
    int    n_out;
    int    last_data;
    int    n_err;
    int    code;
  } vec_t;

  vec_t vecs[12];

  initial begin
    string      pool;
    logic [7:0] fr[$];
    logic [7:0] c;
    bit         x;
    int         nd;

    hdr  = "SENS: ";
    pool = "SEN: 0x9\r";
    vecs[0]  = '{"SENS: 042 ",            1, 42,  0, 0};
    vecs[1]  = '{"SENS: 255\r",           1, 255, 0, 0};
    vecs[2]  = '{"SENS: 256 ",            0, -1,  1, 2};
    vecs[3]  = '{"SEXSENS: 7\n",          1, 7,   1, 1};
    vecs[4]  = '{"SENS: 1234",            0, -1,  1, 1};
    vecs[5]  = '{"SENS: 007\n",           1, 7,   0, 0};
    vecs[6]  = '{"xxSENS: 0 ",            1, 0,   0, 0};
    vecs[7]  = '{"SENS:  5 ",             0, -1,  1, 1};
    vecs[8]  = '{"SENS: 12a",             0, -1,  1, 1};
    vecs[9]  = '{"SENSSENS: 3\n",         1, 3,   1, 1};
    vecs[10] = '{"SENS: 999 ",            0, -1,  1, 2};
    vecs[11] = '{"SENS: 255\rSENS: 256 ", 1, 255, 1, 2};

    m_reset();
    do_reset();

    for (int v = 0; v < 12; v++) begin
      do_reset();
      send_str(vecs[v].txt, 1'b1);
      if (v == 0) chk("latency_42", int'(out_valid), 1);
      idle(3, 1'b1);
      chk("vec_outs", obs_outs, vecs[v].n_out);
      if (vecs[v].n_out != 0) chk("vec_data", obs_data, vecs[v].last_data);
      chk("vec_errs", obs_errs, vecs[v].n_err);
      chk("vec_code", int'(err_code), vecs[v].code);
    end

    // Back-pressure: output and in_ready held while out_ready is low.
    do_reset();
    send_str("SENS: 9 ", 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, "S", 1'b0, x);
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_data", int'(out_data), 9);
      chk("bp_ready", int'(in_ready), 0);
    end
    tick(1'b0, 8'h00, 1'b1, x);
    chk("bp_clear", int'(out_valid), 0);

    // Reset mid-frame and with a pending output.
    do_reset();
    send_str("SENS: 1", 1'b1);
    do_reset();
    send_str("2 ", 1'b1);
    idle(2, 1'b1);
    chk("rst_mid_outs", obs_outs, 0);
    chk("rst_mid_errs", obs_errs, 0);
    send_str("SENS: 5 ", 1'b0);
    do_reset();

    // Long idle inside a frame: held without the timeout, abandoned with it.
    do_reset();
    send_str("SENS", 1'b1);
    idle(15, 1'b1);
    chk("to_early", obs_errs, 0);
    idle(1, 1'b1);
`ifdef SENS_PARSER_TIMEOUT_EN
    chk("to_err", int'(err), 1);
    chk("to_code", int'(err_code), 3);
`else
    chk("no_to_err", int'(err), 0);
    idle(30, 1'b1);
    send_str(": 5 ", 1'b1);
    idle(1, 1'b1);
    chk("no_to_out", obs_data, 5);
`endif

    // Random frames with optional corruption, random gaps and back-pressure.
    do_reset();
    for (int f = 0; f < 200; f++) begin
      fr.delete();
      for (int i = 0; i < 6; i++) begin
        c = hdr[i];
        if ($urandom_range(0, 29) == 0) c = pool[$urandom_range(0, pool.len() - 1)];
        fr.push_back(c);
      end
      nd = $urandom_range(1, 4);
      for (int i = 0; i < nd; i++) fr.push_back(8'h30 + 8'($urandom_range(0, 9)));
      case ($urandom_range(0, 5))
        0:       fr.push_back(8'h0d);
        1:       fr.push_back(8'h0a);
        2:       fr.push_back("S");
        3:       fr.push_back("x");
        default: fr.push_back(8'h20);
      endcase
      foreach (fr[i]) begin
        for (int g = 0; g < 60; g++) begin
          if ($urandom_range(0, 9) < 7) begin
            tick(1'b1, fr[i], 1'($urandom_range(0, 9) < 6), x);
            if (x) break;
          end else begin
            tick(1'b0, 8'($urandom), 1'($urandom_range(0, 9) < 6), x);
          end
        end
      end
      if ($urandom_range(0, 19) == 0) idle($urandom_range(1, 20), 1'b1);
    end
    idle(3, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sens_ascii_parser.md
SENS_ASCII_PARSER -- requirements
Module: sens_ascii_parser

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000: idle cycles between characters before a partial frame is abandoned.
REQ-002 SHALL have port clk  input  1  system clock; all logic on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  in_char holds a character this cycle.
REQ-005 SHALL have port in_char  input  8  ASCII character from the byte stream.
REQ-006 SHALL have port in_ready  output  1  parser accepts in_char this cycle.
REQ-007 SHALL have port out_valid  output  1  out_data holds a decoded value.
REQ-008 SHALL have port out_data  output  8  decoded sensor value, 0-255.
REQ-009 SHALL have port out_ready  input  1  consumer takes out_data this cycle.
REQ-010 SHALL have port err  output  1  one-cycle pulse on a rejected frame.
REQ-011 SHALL have port err_code  output  2  cause of the last error: 1 syntax, 2 overflow, 3 timeout; held until the next error.

Function
REQ-012 SHALL decode frames of the form "SENS: " followed by 1-3 decimal digits and a terminator.
- Terminator is space (0x20), CR (0x0D) or LF (0x0A).
REQ-013 SHALL transfer a character only when in_valid=1 and in_ready=1.
- in_ready = ~out_valid.
REQ-014 SHALL use states IDLE, S1, E, N, S2, COLON, SPACE, DIG.
- IDLE→S1 on 'S'.
- S1→E on 'E', E→N on 'N', N→S2 on 'S', S2→COLON on ':', COLON→SPACE on ' '.
- SPACE→DIG on a digit.
- In IDLE, every other character is discarded silently with no error.
REQ-015 SHALL accumulate digits as acc = acc*10 + (char-0x30) in DIG.
- acc is 10 bits wide and is cleared when a frame starts.
- A digit counter (0-3) counts the digits accepted in the frame.
REQ-016 SHALL, on a terminator in DIG, complete the frame.
- acc ≤ 255: load out_data=acc[7:0] and set out_valid on the next edge, then return to IDLE.
- acc > 255: pulse err with err_code=2 and return to IDLE.
REQ-017 SHALL treat the following as a syntax error (err pulse, err_code=1):
- any unexpected character in S1..SPACE;
- a non-digit, non-terminator character in DIG;
- a 4th digit.
REQ-018 SHALL, when the offending character in REQ-017 is 'S', go to S1 (resynchronise) instead of IDLE; in every other case the FSM goes to IDLE.
REQ-019 SHALL hold out_valid and out_data stable until out_valid=1 and out_ready=1, then clear out_valid on the next edge.
REQ-020 SHALL give latency of exactly one cycle from the accepted terminator to out_valid=1.
REQ-021 SHALL let leading zeros count toward the 3-digit limit; "007" decodes to 7.

Reset
REQ-022 SHALL, on rst=1, set state=IDLE, acc=0, digit count=0, out_valid=0, out_data=0, err=0, err_code=0, timeout counter=0.
REQ-023 SHALL discard any partial frame or pending output when rst is asserted mid-frame, with no err pulse.
REQ-024 SHALL take rst priority over all other inputs in the same cycle.

Configuration
REQ-025 SHALL compile the inter-character timeout only when macro SENS_PARSER_TIMEOUT_EN is defined.
REQ-026 SHALL, with SENS_PARSER_TIMEOUT_EN defined, run the timeout counter as follows:
- it increments every cycle the state is not IDLE and no character transfers;
- it clears on every transfer and whenever the state is IDLE;
- on reaching TIMEOUT_CYCLES it pulses err with err_code=3 and returns the FSM to IDLE.
REQ-027 SHALL, without SENS_PARSER_TIMEOUT_EN, contain no timeout counter, hold partial frames indefinitely, and never produce err_code=3.

Verification
REQ-028 SHALL verify: send "SENS: 042 " with out_ready=1 → out_valid=1 with out_data=42, one cycle after the space; err stays 0.
REQ-029 SHALL verify: send "SENS: 255\r" then "SENS: 256 " → first frame out_data=255; second frame err pulse with err_code=2 and no out_valid.
REQ-030 SHALL verify: send "SEXSENS: 7\n" → err pulse with err_code=1 at 'X', then out_data=7.
REQ-031 SHALL verify: send "SENS: 1234" → err pulse with err_code=1 at '4', FSM back in IDLE.
REQ-032 SHALL verify: hold out_ready=0 after "SENS: 9 " → out_valid and out_data=9 held and in_ready=0 for 5 cycles; out_valid clears the cycle after out_ready=1.
REQ-033 SHALL verify, with SENS_PARSER_TIMEOUT_EN and TIMEOUT_CYCLES=16: send "SENS" then idle 16 cycles → err pulse with err_code=3; assert rst mid-frame → no err and all outputs reset.
